// File: rtl/pair_dist_gen.sv
`default_nettype none
// ============================================================================
// Module   : pair_dist_gen
// Brief    : Walks every point pair (a<b) and streams its squared distance
//            through a fixed 4-stage pipeline.
// Revision : 1.0
// ============================================================================
module pair_dist_gen #(
  parameter int NUM_POINTS = 1000,
  parameter int DIM_W      = 17,
  parameter int DIST_W     = 2*DIM_W+2,
  localparam int PW        = $clog2(NUM_POINTS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pt_wr,
  input  logic [PW-1:0]            pt_addr,
  input  logic [DIM_W-1:0]         pt_x,
  input  logic [DIM_W-1:0]         pt_y,
  input  logic [DIM_W-1:0]         pt_z,
  input  logic [PW:0]              num_pts,
  input  logic                     start,
  output logic                     busy,
  // conn_t packed as {dist, pointa, pointb}
  output logic [DIST_W+2*PW-1:0]   conn_out,
  output logic                     conn_out_vld,
  output logic                     dist_done
);

  localparam int          c_COORD_W = 3*DIM_W;
  localparam logic [PW:0] c_ONE_N   = (PW+1)'(1);
  localparam logic [PW:0] c_TWO_N   = (PW+1)'(2);
  localparam logic [PW-1:0] c_ONE_P = PW'(1);
  localparam logic [PW-1:0] c_TWO_P = PW'(2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_issue;
  logic                w_b_end;
  logic                w_last;
  logic                w_mem_we;

  logic [c_COORD_W-1:0] r_mem [NUM_POINTS];

  logic [PW:0]         r_n;
  logic [PW-1:0]       r_a;
  logic [PW-1:0]       r_b;

  logic                r_v1, r_v2, r_v3;
  logic [c_COORD_W-1:0] r_pa, r_pb;
  logic [PW-1:0]       r_ia1, r_ib1, r_ia2, r_ib2, r_ia3, r_ib3;
  logic [DIST_W-1:0]   w_dist;

  // Point storage is frozen while pairs are being enumerated.
  assign w_mem_we = pt_wr && (int'(pt_addr) < NUM_POINTS) &&
                    ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[pt_addr] <= {pt_z, pt_y, pt_x};
    end
  end

  assign w_b_end = ({1'b0, r_b} == (r_n - c_ONE_N));
  assign w_last  = w_b_end && ({1'b0, r_a} == (r_n - c_TWO_N));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (num_pts >= c_TWO_N) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        w_issue = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Last pair sits in S4 once S1..S3 are empty; done follows it by one cycle.
        if (!(r_v1 || r_v2 || r_v3)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_n <= '0;
      r_a <= '0;
      r_b <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_n <= num_pts;
      r_a <= '0;
      r_b <= c_ONE_P;
    end else if (r_state == ST_RUN) begin
      if (w_b_end) begin
        r_a <= r_a + c_ONE_P;
        r_b <= r_a + c_TWO_P;
      end else begin
        r_b <= r_b + c_ONE_P;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1         <= 1'b0;
      r_v2         <= 1'b0;
      r_v3         <= 1'b0;
      conn_out_vld <= 1'b0;
    end else begin
      r_v1         <= w_issue;
      r_v2         <= r_v1;
      r_v3         <= r_v2;
      conn_out_vld <= r_v3;
    end
  end

  always_ff @(posedge clk) begin
    r_pa  <= r_mem[r_a];
    r_pb  <= r_mem[r_b];
    r_ia1 <= r_a;
    r_ib1 <= r_b;
    r_ia2 <= r_ia1;
    r_ib2 <= r_ib1;
    r_ia3 <= r_ia2;
    r_ib3 <= r_ib2;
  end

  for (genvar i = 0; i < 3; i++) begin : g_axis
    logic [DIM_W-1:0]   w_ca;
    logic [DIM_W-1:0]   w_cb;
    logic [2*DIM_W-1:0] w_d_ext;
    logic [DIM_W-1:0]   r_d;
    logic [2*DIM_W-1:0] r_sq;

    assign w_ca    = r_pa[i*DIM_W +: DIM_W];
    assign w_cb    = r_pb[i*DIM_W +: DIM_W];
    assign w_d_ext = {{DIM_W{1'b0}}, r_d};

    always_ff @(posedge clk) begin
      r_d  <= (w_ca >= w_cb) ? (w_ca - w_cb) : (w_cb - w_ca);
      r_sq <= w_d_ext * w_d_ext;
    end
  end

  assign w_dist = DIST_W'(g_axis[0].r_sq) + DIST_W'(g_axis[1].r_sq) +
                  DIST_W'(g_axis[2].r_sq);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conn_out <= '0;
    end else if (r_v3) begin
      conn_out <= {w_dist, r_ia3, r_ib3};
    end
  end

  assign busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign dist_done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pair_dist_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pair_dist_gen
// Brief    : Directed self-checking bench for pair_dist_gen.
// Revision : 1.0
// ============================================================================
module tb_pair_dist_gen;

  localparam int PW     = 10;
  localparam int DIM_W  = 17;
  localparam int DIST_W = 36;
  localparam int CW     = DIST_W + 2*PW;
  localparam int c_MAXC = 131071;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pt_wr;
  logic [PW-1:0]     pt_addr;
  logic [DIM_W-1:0]  pt_x, pt_y, pt_z;
  logic [PW:0]       num_pts;
  logic              start;
  logic              busy;
  logic [CW-1:0]     conn_out;
  logic              conn_out_vld;
  logic              dist_done;

  always #5 clk = ~clk;

  pair_dist_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pt_wr        (pt_wr),
    .pt_addr      (pt_addr),
    .pt_x         (pt_x),
    .pt_y         (pt_y),
    .pt_z         (pt_z),
    .num_pts      (num_pts),
    .start        (start),
    .busy         (busy),
    .conn_out     (conn_out),
    .conn_out_vld (conn_out_vld),
    .dist_done    (dist_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int     cyc = 0;
  longint q_dist[$];
  int     q_a[$], q_b[$], q_cyc[$];
  int     busy_cnt  = 0;
  int     done_rise = -1;
  logic   prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (conn_out_vld) begin
      q_dist.push_back(longint'(conn_out[CW-1 -: DIST_W]));
      q_a.push_back(int'(conn_out[2*PW-1 -: PW]));
      q_b.push_back(int'(conn_out[PW-1:0]));
      q_cyc.push_back(cyc);
    end
    if (busy) busy_cnt++;
    if (dist_done && !prev_done) done_rise = cyc;
    prev_done = dist_done;
  end

  longint mx[32], my[32], mz[32];

  function automatic longint adiff(input longint p, input longint q);
    return (p > q) ? p - q : q - p;
  endfunction

  function automatic longint mdist(input int a, input int b);
    longint dx, dy, dz;
    dx = adiff(mx[a], mx[b]);
    dy = adiff(my[a], my[b]);
    dz = adiff(mz[a], mz[b]);
    return dx*dx + dy*dy + dz*dz;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic load(input int addr, input int x, input int y, input int z);
    pt_wr   = 1'b1;
    pt_addr = PW'(addr);
    pt_x    = DIM_W'(x);
    pt_y    = DIM_W'(y);
    pt_z    = DIM_W'(z);
    step();
    pt_wr   = 1'b0;
    mx[addr] = longint'(x);
    my[addr] = longint'(y);
    mz[addr] = longint'(z);
  endtask

  task automatic load_tri();
    load(0, 0, 0, 0);
    load(1, 3, 4, 0);
    load(2, 1, 1, 1);
  endtask

  task automatic chk_tri(input string tag, input int base);
    chk({tag, " d01"}, q_dist[base],   25);
    chk({tag, " d02"}, q_dist[base+1], 3);
    chk({tag, " d12"}, q_dist[base+2], 14);
  endtask

  // Starts a run of n points, waits for dist_done, and checks count, timing and content.
  task automatic run(input string tag, input int n, input bit disturb, output int base);
    int  b0, ts, p, k, last;
    bit  ok;
    base = q_dist.size();
    b0   = busy_cnt;
    p    = n*(n-1)/2;
    num_pts = (PW+1)'(n);
    start   = 1'b1;
    ts      = cyc;
    step();
    start   = 1'b0;
    if (disturb) begin
      pt_wr   = 1'b1;
      pt_addr = '0;
      pt_x    = DIM_W'(12345);
      pt_y    = DIM_W'(777);
      pt_z    = DIM_W'(99999);
      num_pts = (PW+1)'(2);
      start   = 1'b1;
      step();
      pt_wr   = 1'b0;
      start   = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < p + 40; i++) begin
      if (dist_done) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk({tag, " done_seen"}, longint'(ok), 1);
    repeat (3) step();
    chk({tag, " count"}, q_dist.size() - base, p);
    if (n >= 2 && q_dist.size() > base) begin
      last = q_dist.size() - 1;
      chk({tag, " first_lat"}, q_cyc[base], ts + 5);
      chk({tag, " gapless"}, q_cyc[last] - q_cyc[base], p - 1);
      chk({tag, " done_after_last"}, done_rise, q_cyc[last] + 1);
      chk({tag, " busy_cycles"}, busy_cnt - b0, p + 4);
    end else begin
      chk({tag, " done_rise"}, done_rise, ts + 1);
      chk({tag, " busy_cycles"}, busy_cnt - b0, 0);
    end
    k = base;
    for (int a = 0; a < n; a++) begin
      for (int b = a + 1; b < n; b++) begin
        if (k < q_dist.size()) begin
          chk({tag, " pa"}, q_a[k], a);
          chk({tag, " pb"}, q_b[k], b);
          chk({tag, " dist"}, q_dist[k], mdist(a, b));
        end
        k++;
      end
    end
  endtask

  initial begin
    int base, cnt0, dr0;
    bit ok;
    rst_n   = 1'b0;
    pt_wr   = 1'b0;
    pt_addr = '0;
    pt_x    = '0;
    pt_y    = '0;
    pt_z    = '0;
    num_pts = '0;
    start   = 1'b0;
    repeat (3) step();
    chk("rst vld",  longint'(conn_out_vld), 0);
    chk("rst done", longint'(dist_done), 0);
    chk("rst busy", longint'(busy), 0);
    chk("rst conn", longint'(conn_out), 0);
    rst_n = 1'b1;
    step();

    load_tri();
    run("tri", 3, 1'b0, base);
    chk_tri("tri", base);

    do_reset();
    load(0, 0, 0, 0);
    load(1, c_MAXC, c_MAXC, c_MAXC);
    run("max", 2, 1'b0, base);
    chk("max dist", q_dist[base], 64'd51538821123);

    do_reset();
    load(0, c_MAXC, c_MAXC, c_MAXC);
    load(1, 0, 0, 0);
    run("max_swap", 2, 1'b0, base);
    chk("max_swap dist", q_dist[base], 64'd51538821123);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      load(i, int'($urandom_range(c_MAXC, 0)), int'($urandom_range(c_MAXC, 0)),
           int'($urandom_range(c_MAXC, 0)));
    end
    run("rand20", 20, 1'b0, base);

    do_reset();
    run("n1", 1, 1'b0, base);
    do_reset();
    run("n0", 0, 1'b0, base);

    // Reset in the middle of a 10-point run.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      load(i, int'($urandom_range(c_MAXC, 0)), int'($urandom_range(c_MAXC, 0)),
           int'($urandom_range(c_MAXC, 0)));
    end
    base    = q_dist.size();
    dr0     = done_rise;
    num_pts = (PW+1)'(10);
    start   = 1'b1;
    step();
    start   = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (q_dist.size() - base >= 20) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("midrst reach20", longint'(ok), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cnt0  = q_dist.size();
    repeat (30) step();
    chk("midrst no_more", q_dist.size() - cnt0, 0);
    chk("midrst done_low", longint'(dist_done), 0);
    chk("midrst no_rise", done_rise, dr0);
    load_tri();
    run("post_rst", 3, 1'b0, base);
    chk_tri("post_rst", base);

    // Writes and a second start during RUN must be ignored.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      load(i, int'($urandom_range(c_MAXC, 0)), int'($urandom_range(c_MAXC, 0)),
           int'($urandom_range(c_MAXC, 0)));
    end
    run("disturb", 6, 1'b1, base);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pair_dist_gen.md
Name: pair_dist_gen

Overview:
- Upstream producer for the insertion sorter. Holds the loaded 3-D junction-box coordinates and walks every unordered point pair (a<b).
- Computes the squared Euclidean distance of each pair and streams one conn_t per cycle into the sorter.
- Asserts dist_done once the last pair has been emitted.
- Pairs are never dropped; the sorter accepts one entry per cycle with no backpressure.

Parameters:
- NUM_POINTS, 1000, maximum number of points stored; sets the index width PW = $clog2(NUM_POINTS).
- DIM_W, 17, unsigned width of each coordinate.
- DIST_W, 2*DIM_W+2, width of conn_t.dist; holds the worst case 3*(2^DIM_W-1)^2 without overflow.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- pt_wr  in  1  point write strobe.
- pt_addr  in  PW  point index to write.
- pt_x  in  DIM_W  X coordinate.
- pt_y  in  DIM_W  Y coordinate.
- pt_z  in  DIM_W  Z coordinate.
- num_pts  in  PW+1  number of valid points; sampled on start.
- start  in  1  one-cycle pulse that begins pair enumeration.
- busy  out  1  high from the accepted start until dist_done rises.
- conn_out  out  conn_t  fields: dist [DIST_W], pointa [PW], pointb [PW].
- conn_out_vld  out  1  conn_out qualifier.
- dist_done  out  1  sticky "all pairs emitted" flag.

Behaviour:
- Storage: register array NUM_POINTS x 3*DIM_W. Writes are accepted in IDLE and DONE only; pt_wr in RUN/DRAIN is ignored. Reset does not clear storage.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start when num_pts >= 2. Latches n = num_pts and sets a = 0, b = 1.
- IDLE -> DONE on start when num_pts < 2. No conn_out_vld is ever asserted; dist_done rises the cycle after start.
- RUN: issues pair (a,b) every cycle.
  - If b == n-1: a <= a+1, b <= a+2.
  - Otherwise: b <= b+1.
  - After issuing (n-2, n-1), go to DRAIN.
- DRAIN: waits until the pipeline is empty, then goes to DONE. dist_done is set that cycle and busy drops in the same cycle.
- DONE: dist_done stays high. start is ignored until reset; a new run requires rst_n low first.
- start in RUN or DRAIN is ignored.
- Pipeline, fixed 4-cycle latency from issue to conn_out_vld:
  - S1: register read of both points.
  - S2: per-axis absolute difference |pa-pb| (DIM_W bits, unsigned, no wrap).
  - S3: per-axis square (2*DIM_W bits).
  - S4: sum of the three squares into DIST_W bits, registered onto conn_out.
- pointa = a and pointb = b travel alongside the data. conn_out_vld is high for exactly one cycle per pair, and pairs arrive back to back.
- Emission order is lexicographic by (a,b). Total count is n*(n-1)/2.
- The last conn_out_vld occurs 4 cycles after the last issue. dist_done rises the cycle after the last conn_out_vld, never in the same cycle.
- conn_out holds its last value when not valid; the consumer qualifies it with conn_out_vld.
- Reset values: conn_out_vld=0, dist_done=0, busy=0, conn_out='0, state=IDLE, pipeline valids cleared.
- Reset mid-RUN/DRAIN: all in-flight pairs are discarded; no conn_out_vld after the reset cycle; dist_done stays 0.

Test Plan:
- Load (0,0,0),(3,4,0),(1,1,1), num_pts=3, start -> exactly 3 outputs, in order (0,1,25), (0,2,3), (1,2,14). First conn_out_vld is 4 cycles after the first RUN issue. dist_done rises 1 cycle after the third output.
- Load (0,0,0) and (131071,131071,131071), num_pts=2 -> single output dist=51538821123, no truncation. Repeat with the points swapped -> same dist (abs-diff check).
- num_pts=20 with random coordinates -> 190 back-to-back outputs with no gaps. Every (a<b) pair appears once, and each dist matches the scoreboard.
- num_pts=1 and num_pts=0 -> zero conn_out_vld; dist_done=1 the cycle after start; busy never high beyond that.
- num_pts=10, assert rst_n=0 for 1 cycle after 20 outputs -> no further outputs and dist_done=0. Then reload, start with num_pts=3 -> the normal 3-output sequence.
- pt_wr with new values during RUN, and a second start pulse during RUN -> both ignored; results equal the pre-run point set and the count is unchanged.
